twiddle_mult_pipe: RTL
======================

TWIDDLE_MULT_PIPE -- requirements
Module: twiddle_mult_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning signed input component width.
REQ-002 SHALL have parameter TW_W, default 18, meaning signed twiddle width, with 1.0 = 2^(TW_W-2).
REQ-003 SHALL have parameter LOG2_NFFT, default 4, range 2..10, meaning FFT size N = 2^LOG2_NFFT.
REQ-004 SHALL have parameter TAG_W, default 8, meaning sideband tag width.
REQ-005 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: input sample valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts input this cycle.
REQ-009 SHALL have ports in_data_i and in_data_q, input, DATA_W bits each: signed sample.
REQ-010 SHALL have port fi_deg, input, LOG2_NFFT-1 bits: twiddle index k, 0..N/2-1.
REQ-011 SHALL have port inverse, input, 1 bit: 0 = forward (e^-j2πk/N), 1 = inverse (e^+j2πk/N); sampled with the data.
REQ-012 SHALL have port in_tag, input, TAG_W bits: carried unchanged alongside the sample.
REQ-013 SHALL have port out_valid, output, 1 bit: result valid.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-015 SHALL have ports out_data_minus_i and out_data_minus_q, output, DATA_W+1 bits each: rotated sample.
REQ-016 SHALL have ports out_data_plus_i and out_data_plus_q, output, DATA_W+1 bits each: negated rotated sample.
REQ-017 SHALL have port out_tag, output, TAG_W bits: tag of the current result.

Function
REQ-018 SHALL implement a 4-stage pipeline: S1 register input and read the ROM, S2 four products, S3 add/subtract, S4 scale and drive outputs.
REQ-019 SHALL have a latency of exactly 4 cycles from an accepted input to out_valid when out_ready is held high.
REQ-020 SHALL advance all stages only when ce = !out_valid | out_ready; in_ready SHALL equal ce; while ce=0, every stage SHALL hold; no sample is lost or duplicated.
REQ-021 SHALL accept a transfer when in_valid & in_ready, and emit one when out_valid & out_ready; order SHALL be preserved.
REQ-022 SHALL sustain a throughput of 1 sample/cycle while out_ready=1.
REQ-023 SHALL compute, for a forward rotation with c=cos, s=sin: re = a·c + b·s, im = b·c − a·s.
REQ-024 SHALL compute, for an inverse rotation: re = a·c − b·s, im = b·c + a·s.
REQ-025 SHALL keep full-precision sums, then arithmetic-shift them right by TW_W-2 and truncate them to DATA_W+1 bits; the result cannot overflow.
REQ-026 SHALL take ROM contents from "cos<N>.mem" and "sin<N>.mem", each N/2 entries of TW_W-bit hex: round(cos/sin(2πk/N)·2^(TW_W-2)).
REQ-027 SHALL bypass the multipliers for k=0 (re=a, im=b) and k=N/4 (forward: re=b, im=−a; inverse: re=−b, im=a), using the same 4-cycle latency.
REQ-028 SHALL drive out_data_plus_* as the two's-complement negation of out_data_minus_*; the output range excludes −2^DATA_W, so negation cannot overflow.
REQ-029 SHALL hold out_data_*/out_tag stable while out_valid=1 and out_ready=0.
REQ-030 SHALL leave an out-of-range fi_deg undefined; the bench SHALL not drive one.

Reset
REQ-031 SHALL, on the first clk edge with reset=1, clear all stage valid bits, making out_valid=0 and in_ready=1 the cycle after.
REQ-032 SHALL reset out_data_* and out_tag to 0; other pipeline data registers are not reset.
REQ-033 SHALL discard all in-flight samples when reset is asserted mid-stream; any transfer on the reset cycle is ignored.

Configuration
REQ-034 SHALL, with macro TWMUL_ROUND_EN defined, add 2^(TW_W-3) to the sums before the shift (round half up).
REQ-035 SHALL, without TWMUL_ROUND_EN, truncate the sums (floor toward −∞); latency is identical in both builds.

Verification (DATA_W=16, TW_W=18, LOG2_NFFT=4)
REQ-036 SHALL cover: k=0, forward, in (1000,−2000), tag 0x5A -> 4 cycles later minus (1000,−2000), plus (−1000,2000), tag 0x5A.
REQ-037 SHALL cover: k=4, in (100,200) -> forward minus (200,−100); inverse minus (−200,100).
REQ-038 SHALL cover: k=2 (c=s=46341), forward, in (10000,0) -> minus (7071,−7072); in (1,0) -> re 0 without the macro, re 1 with it.
REQ-039 SHALL cover: 6 back-to-back samples with out_ready low for 3 cycles mid-burst -> in_ready low those cycles, all 6 outputs in order, outputs stable while stalled.
REQ-040 SHALL cover: reset pulsed for 1 cycle with 3 samples in flight -> out_valid=0 from the next cycle, no stale output afterward, the next input emerges 4 cycles after acceptance.

Source files
------------

// File: rtl/twiddle_mult_pipe.sv
// Four-stage complex twiddle rotator with valid/ready flow control and sideband tag.
// Define TWMUL_ROUND_EN to round the scaled results half-up instead of flooring them.
module twiddle_mult_pipe #(
  parameter int DATA_W    = 16,
  parameter int TW_W      = 18,
  parameter int LOG2_NFFT = 4,
  parameter int TAG_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data_i,
  input  logic signed [DATA_W-1:0] in_data_q,
  input  logic [LOG2_NFFT-2:0]     fi_deg,
  input  logic                     inverse,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W:0]   out_data_minus_i,
  output logic signed [DATA_W:0]   out_data_minus_q,
  output logic signed [DATA_W:0]   out_data_plus_i,
  output logic signed [DATA_W:0]   out_data_plus_q,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int N      = 1 << LOG2_NFFT;
  localparam int HALF   = N / 2;
  localparam int SH     = TW_W - 2;
  localparam int PROD_W = DATA_W + TW_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam int OUT_W  = DATA_W + 1;
  localparam logic [LOG2_NFFT-2:0] QTR_IDX = (LOG2_NFFT-1)'(N / 4);
`ifdef TWMUL_ROUND_EN
  localparam logic signed [SUM_W-1:0] RND_OFS = SUM_W'(1) <<< (SH - 1);
`else
  localparam logic signed [SUM_W-1:0] RND_OFS = '0;
`endif

  typedef enum logic [1:0] {MODE_MUL, MODE_PASS0, MODE_PASS90} mode_e;

  // Elaboration-time table entry: round(cos/sin(2*pi*k/N) * 2^(TW_W-2)).
  function automatic logic signed [TW_W-1:0] tw_val(input int k, input bit want_cos);
    real x, term, acc, scaled;
    int  r;
    x = 2.0 * 3.14159265358979323846 * $itor(k) / $itor(N);
    if (want_cos) begin
      term = 1.0;
      acc  = 1.0;
    end else begin
      term = x;
      acc  = x;
    end
    for (int n = 1; n < 30; n++) begin
      if (want_cos) term = -term * x * x / $itor((2 * n - 1) * (2 * n));
      else          term = -term * x * x / $itor((2 * n) * (2 * n + 1));
      acc += term;
    end
    scaled = acc * $itor(1 << SH);
    r = (scaled >= 0.0) ? $rtoi(scaled + 0.5) : -$rtoi(0.5 - scaled);
    return TW_W'(r);
  endfunction

  logic signed [TW_W-1:0] cos_rom [HALF];
  logic signed [TW_W-1:0] sin_rom [HALF];

  for (genvar g = 0; g < HALF; g++) begin : g_rom
    localparam logic signed [TW_W-1:0] COS_V = tw_val(g, 1'b1);
    localparam logic signed [TW_W-1:0] SIN_V = tw_val(g, 1'b0);
    assign cos_rom[g] = COS_V;
    assign sin_rom[g] = SIN_V;
  end

  logic ce;
  logic v1_q, v2_q, v3_q, v4_q;

  logic signed [DATA_W-1:0] a1_q, b1_q, a2_q, b2_q;
  logic signed [TW_W-1:0]   c1_q, s1_q;
  mode_e                    mode_d, mode1_q, mode2_q;
  logic                     inv1_q, inv2_q;
  logic [TAG_W-1:0]         tag1_q, tag2_q, tag3_q, tag4_q;
  logic signed [PROD_W-1:0] ac_d, bs_d, bc_d, as_d, ac2_q, bs2_q, bc2_q, as2_q;
  logic signed [SUM_W-1:0]  re3_d, im3_d, re3_q, im3_q, re_rnd, im_rnd;
  logic signed [OUT_W-1:0]  out_i_d, out_q_d, out_i_q, out_q_q;

  // The whole pipeline moves as one; a stalled output freezes every stage.
  assign ce       = !v4_q || out_ready;
  assign in_ready = ce;

  always_comb begin
    mode_d = MODE_MUL;
    if (fi_deg == '0)          mode_d = MODE_PASS0;
    else if (fi_deg == QTR_IDX) mode_d = MODE_PASS90;
  end

  assign ac_d = PROD_W'(a1_q) * PROD_W'(c1_q);
  assign bs_d = PROD_W'(b1_q) * PROD_W'(s1_q);
  assign bc_d = PROD_W'(b1_q) * PROD_W'(c1_q);
  assign as_d = PROD_W'(a1_q) * PROD_W'(s1_q);

  // Bypass paths are pre-shifted so the common scaling stage recovers them exactly.
  always_comb begin
    re3_d = inv2_q ? SUM_W'(ac2_q) - SUM_W'(bs2_q) : SUM_W'(ac2_q) + SUM_W'(bs2_q);
    im3_d = inv2_q ? SUM_W'(bc2_q) + SUM_W'(as2_q) : SUM_W'(bc2_q) - SUM_W'(as2_q);
    case (mode2_q)
      MODE_PASS0: begin
        re3_d = SUM_W'(a2_q) <<< SH;
        im3_d = SUM_W'(b2_q) <<< SH;
      end
      MODE_PASS90: begin
        re3_d = inv2_q ? -(SUM_W'(b2_q) <<< SH) : (SUM_W'(b2_q) <<< SH);
        im3_d = inv2_q ?  (SUM_W'(a2_q) <<< SH) : -(SUM_W'(a2_q) <<< SH);
      end
      default: ;
    endcase
  end

  always_comb begin
    re_rnd  = re3_q + RND_OFS;
    im_rnd  = im3_q + RND_OFS;
    out_i_d = OUT_W'(re_rnd >>> SH);
    out_q_d = OUT_W'(im_rnd >>> SH);
  end

  // NOTE: datapath registers carry no reset; only the valid bits and the visible outputs need a known value.
  always_ff @(posedge clk) begin
    if (ce) begin
      a1_q    <= in_data_i;
      b1_q    <= in_data_q;
      c1_q    <= cos_rom[fi_deg];
      s1_q    <= sin_rom[fi_deg];
      mode1_q <= mode_d;
      inv1_q  <= inverse;
      tag1_q  <= in_tag;
      ac2_q   <= ac_d;
      bs2_q   <= bs_d;
      bc2_q   <= bc_d;
      as2_q   <= as_d;
      a2_q    <= a1_q;
      b2_q    <= b1_q;
      mode2_q <= mode1_q;
      inv2_q  <= inv1_q;
      tag2_q  <= tag1_q;
      re3_q   <= re3_d;
      im3_q   <= im3_d;
      tag3_q  <= tag2_q;
    end
  end

  // NOTE: non-blocking assignments keep every stage sampling the previous stage's old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      v4_q    <= 1'b0;
      out_i_q <= '0;
      out_q_q <= '0;
      tag4_q  <= '0;
    end else if (ce) begin
      v1_q    <= in_valid;
      v2_q    <= v1_q;
      v3_q    <= v2_q;
      v4_q    <= v3_q;
      out_i_q <= out_i_d;
      out_q_q <= out_q_d;
      tag4_q  <= tag3_q;
    end
  end

  assign out_valid        = v4_q;
  assign out_data_minus_i = out_i_q;
  assign out_data_minus_q = out_q_q;
  assign out_data_plus_i  = -out_i_q;
  assign out_data_plus_q  = -out_q_q;
  assign out_tag          = tag4_q;

endmodule
